// File: rtl/rr_arb4_idx.sv
// rtl/rr_arb4_idx.sv - registered 4-way round-robin arbiter with binary grant index and hold limit
module rr_arb4_idx #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       preempt
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state;
  logic [1:0]      r_ptr;
  logic [1:0]      r_gnt_idx;
  logic            r_gnt_vld;
  logic            r_preempt;
  logic [CW-1:0]   r_hold_cnt;

  state_t          w_state_nxt;
  logic [1:0]      w_ptr_nxt;
  logic [1:0]      w_gnt_idx_nxt;
  logic            w_gnt_vld_nxt;
  logic            w_preempt_nxt;
  logic [CW-1:0]   w_hold_cnt_nxt;

  logic [3:0]      w_req_masked;
  logic [1:0]      w_base;
  logic [1:0]      w_winner;
  logic            w_owner_req;
  logic            w_at_cap;
  logic            w_release;

  // Lowest offset from base wins; loop runs downward so the nearest set bit is assigned last.
  function automatic logic [1:0] f_pick(input logic [3:0] req_v, input logic [1:0] base);
    logic [1:0] idx;
    f_pick = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (req_v[idx]) f_pick = idx;
    end
  endfunction

  always_comb begin
    w_req_masked = req;
    w_base       = r_ptr;
    if (r_state == S_GRANT) begin
      w_req_masked[r_gnt_idx] = 1'b0;
      w_base                  = r_gnt_idx + 2'd1;
    end
    w_winner    = f_pick(w_req_masked, w_base);
    w_owner_req = req[r_gnt_idx];
    w_at_cap    = (r_hold_cnt == CW'(MAX_HOLD));
    w_release   = done || !w_owner_req || w_at_cap;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_gnt_idx_nxt  = r_gnt_idx;
    w_gnt_vld_nxt  = r_gnt_vld;
    w_preempt_nxt  = 1'b0;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_gnt_idx_nxt  = w_winner;
          w_gnt_vld_nxt  = 1'b1;
          w_hold_cnt_nxt = CW'(1);
          w_state_nxt    = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_ptr_nxt     = r_gnt_idx + 2'd1;
          // Preempt only when the hold limit alone forced the release.
          w_preempt_nxt = w_at_cap && !done && w_owner_req;
          if (|w_req_masked) begin
            w_gnt_idx_nxt  = w_winner;
            w_hold_cnt_nxt = CW'(1);
          end else begin
            w_gnt_vld_nxt = 1'b0;
            w_state_nxt   = S_IDLE;
          end
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_gnt_vld_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'b00;
      r_gnt_idx  <= 2'b00;
      r_gnt_vld  <= 1'b0;
      r_preempt  <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gnt_idx  <= w_gnt_idx_nxt;
      r_gnt_vld  <= w_gnt_vld_nxt;
      r_preempt  <= w_preempt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  assign gnt_idx = r_gnt_idx;
  assign gnt_vld = r_gnt_vld;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_rr_arb4_idx.sv
// tb/tb_rr_arb4_idx.sv - scoreboard bench for rr_arb4_idx with directed vectors
module tb_rr_arb4_idx;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       preempt;

  typedef struct {
    string      name;
    logic       vld;
    logic [1:0] idx;
    logic       pre;
  } exp_t;

  exp_t q[$];
  int   checks_total;
  int   checks_passed;

  rr_arb4_idx #(.MAX_HOLD(8), .CW(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input string nm, input logic rn, input logic [3:0] r, input logic d,
                      input logic ev, input logic [1:0] ei, input logic ep);
    exp_t e;
    @(negedge clk);
    rst_n = rn;
    req   = r;
    done  = d;
    e.name = nm;
    e.vld  = ev;
    e.idx  = ei;
    e.pre  = ep;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks_total++;
        if (gnt_vld !== e.vld || gnt_idx !== e.idx || preempt !== e.pre)
          $display("FAIL %s: got vld=%b idx=%b pre=%b, expected vld=%b idx=%b pre=%b",
                   e.name, gnt_vld, gnt_idx, preempt, e.vld, e.idx, e.pre);
        else
          checks_passed++;
      end
    end
  end

  initial begin : stimulus
    int wait_cyc;
    checks_total  = 0;
    checks_passed = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;

    step("reset0", 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
    step("reset1", 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);

    step("single_grant", 1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    step("single_done",  1'b1, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b0);
    step("idle_hold_idx", 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0);

    // ptr is 3 here, so requester 3 beats requester 0.
    step("wrap_first",  1'b1, 4'b1001, 1'b0, 1'b1, 2'd3, 1'b0);
    step("wrap_second", 1'b1, 4'b1001, 1'b1, 1'b1, 2'd0, 1'b0);
    step("wrap_third",  1'b1, 4'b1001, 1'b1, 1'b1, 2'd3, 1'b0);
    step("drop_req",    1'b1, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0);

    step("rot_g0", 1'b1, 4'b1111, 1'b0, 1'b1, 2'd0, 1'b0);
    step("rot_h0", 1'b1, 4'b1111, 1'b0, 1'b1, 2'd0, 1'b0);
    for (int g = 1; g <= 4; g++) begin
      step("rot_switch", 1'b1, 4'b1111, 1'b1, 1'b1, 2'(g), 1'b0);
      if (g < 4) begin
        step("rot_hold_a", 1'b1, 4'b1111, 1'b0, 1'b1, 2'(g), 1'b0);
        step("rot_hold_b", 1'b1, 4'b1111, 1'b0, 1'b1, 2'(g), 1'b0);
      end
    end
    step("rot_idle", 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    step("pre_reset", 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++)
      step("pre_hold0", 1'b1, 4'b0011, 1'b0, 1'b1, 2'd0, 1'b0);
    step("pre_to1", 1'b1, 4'b0011, 1'b0, 1'b1, 2'd1, 1'b1);
    for (int i = 0; i < 7; i++)
      step("pre_hold1", 1'b1, 4'b0011, 1'b0, 1'b1, 2'd1, 1'b0);
    step("pre_to0", 1'b1, 4'b0011, 1'b0, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 7; i++)
      step("cap_hold0", 1'b1, 4'b0011, 1'b0, 1'b1, 2'd0, 1'b0);
    step("cap_with_done", 1'b1, 4'b0011, 1'b1, 1'b1, 2'd1, 1'b0);
    step("cap_idle", 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);

    step("mid_grant",  1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    step("mid_reset",  1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0);
    step("post_reset", 1'b1, 4'b1100, 1'b0, 1'b1, 2'd2, 1'b0);
    step("post_next",  1'b1, 4'b1100, 1'b1, 1'b1, 2'd3, 1'b0);
    step("post_idle",  1'b1, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0);
    step("idle_done",  1'b1, 4'b0000, 1'b1, 1'b0, 2'd3, 1'b0);
    step("idle_quiet", 1'b1, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (q.size() > 0) begin
      checks_total++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
